spi_csr_bridge: RTL
===================

# spi_csr_bridge

SPI mode-0 slave that turns host transactions into an 8-bit control/status register bus inside the EPDC clock domain. It consumes the `spi_cs`/`spi_sck`/`spi_mosi` signals after their two-flop synchronizers and drives `SPI_MISO`. Its register bus feeds the CSR file that supplies `caster` configuration and the power-OK status. All edge detection is done by oversampling in `clk`; no logic is clocked by SCK.

## Interface
Parameters:
- `ADDR_W`, 7 — register address width; command byte is {rw, addr[6:0]}.
- `DATA_W`, 8 — register data width; fixed to one SPI byte.

Ports:
- `clk` in 1 — EPDC clock; single clock domain.
- `rst_n` in 1 — asynchronous, active-low reset.
- `spi_cs` in 1 — chip select, active low, already synchronized to `clk`.
- `spi_sck` in 1 — SPI clock, already synchronized.
- `spi_mosi` in 1 — host data, already synchronized.
- `spi_miso` out 1 — slave data, MSB first.
- `csr_addr` out ADDR_W — register address for the current access.
- `csr_wr` out 1 — one-cycle write strobe.
- `csr_wdata` out DATA_W — write data; valid while `csr_wr`=1.
- `csr_rd` out 1 — one-cycle read strobe.
- `csr_rdata` in DATA_W — read data; must be valid the cycle after `csr_rd`.
- `frame_abort` out 1 — one-cycle pulse when CS rises with a partial byte.

## Operation
- Registers `sck_q` and `cs_q` (1 cycle delayed) detect edges.
  - rise = `spi_sck & ~sck_q`; fall = `~spi_sck & sck_q`.
  - Edges are honoured only while `spi_cs`=0.
- FSM states:
  - IDLE: CS high.
  - CMD: receiving byte 0.
  - WDATA: write data bytes.
  - RDATA: read data bytes.
- Transitions:
  - IDLE→CMD on CS fall. This clears `bit_cnt` (3 bits), `rx_sr`, and `tx_sr`.
  - Any state→IDLE on CS rise.
- Receive: every rise shifts `rx_sr` = {rx_sr[6:0], spi_mosi} and increments `bit_cnt`. A byte completes when `bit_cnt` wraps 7→0.
- Byte completion in CMD:
  - Latch `csr_addr` = rx[6:0].
  - rx[7]=0 → go to WDATA.
  - rx[7]=1 → go to RDATA and issue a prefetch (see below).
- Byte completion in WDATA: on the next cycle, `csr_wr`=1, `csr_wdata`=rx byte, `csr_addr` = current address. The address is then advanced (see Configuration).
- Byte completion in RDATA: advance the address, then issue a prefetch.
- Prefetch:
  - `csr_rd`=1 for one cycle at the current address.
  - The following cycle, `tx_sr` ← `csr_rdata`.
- Transmit:
  - `spi_miso` = `tx_sr[7]`.
  - On fall with `bit_cnt`≠0, `tx_sr` shifts left and fills with 0.
  - A fall with `bit_cnt`=0 (the fall after a byte boundary) does not shift, so bit 7 of the new byte is already presented.
- `spi_miso`=0 in IDLE, during CMD, and in WDATA.
- Address arithmetic is modulo 2^ADDR_W: 0x7F+1 → 0x00.
- CS rise with `bit_cnt`≠0:
  - Discard the partial byte; no `csr_wr` is issued.
  - Pulse `frame_abort` for one cycle.
  - If a strobe for a completed byte is already pending, it still issues.
- Reset (`rst_n`=0), which may arrive mid-frame, forces:
  - IDLE, `bit_cnt`=0;
  - `spi_miso`=0, `csr_wr`=0, `csr_rd`=0, `frame_abort`=0;
  - `csr_addr`=0, `csr_wdata`=0.
- After reset, the first transaction starts only at a fresh CS falling edge. CS already low when reset releases is treated as IDLE until CS goes high and low again.

## Timing
- Requirement on the host: SCK high and low phases each ≥4 `clk` cycles. CS setup to the first SCK rise and CS hold after the last SCK fall ≥4 cycles.
- Write strobe: `csr_wr` asserts 1 cycle after the `clk` in which the 8th rise is detected. Detection itself is 1 cycle after `spi_sck` changes.
- Read path:
  - `csr_rd` asserts 1 cycle after byte completion.
  - `tx_sr` loads 1 cycle later.
  - MISO is therefore valid 3 cycles after the detected 8th rise, before the next fall.
- `csr_wr` and `csr_rd` are never asserted in the same cycle. Each strobe occurs at most once per byte.

## Configuration
- Macro `SPI_CSR_AUTOINC_EN`:
  - Defined: the address increments by 1 after each data byte, for both writes and reads.
  - Undefined: the address stays fixed for the whole frame. Repeated writes then stream to one register, and repeated reads re-read it (FIFO-port style).

## Test plan
- Write burst: CS low, send 0x10, 0xAA, 0x55, CS high → `csr_wr` at addr 0x10 data 0xAA, then addr 0x11 data 0x55 (AUTOINC defined). Exactly 2 strobes; `spi_miso` stays 0.
- Read burst: send 0x85 then two dummy bytes, with the model returning 0x3C@0x05 and 0xC3@0x06 → MISO shows 0x3C then 0xC3 MSB first. `csr_rd` fires for addresses 0x05, 0x06, and 0x07 (prefetch).
- Wrap: write command 0x7F with 2 data bytes → writes to 0x7F then 0x00.
- Abort: send 0x02, 0x11, then 5 bits, CS high → one write (0x02←0x11). `frame_abort` pulses once; no second `csr_wr`.
- Reset mid-frame: assert `rst_n`=0 after 3 bits of a data byte → all outputs at their reset values. The next clean frame (write 0x01←0x99) produces exactly one correct strobe.
- Without the macro: write command 0x20 with 3 bytes → three `csr_wr` strobes, all at addr 0x20.

Source files
------------

// File: rtl/spi_csr_bridge_if.sv
// SPI pin and CSR register-bus bundle for spi_csr_bridge.
// The slave modport is the bridge; the master modport is the host/CSR-file side.
interface spi_csr_bridge_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
);
  logic              spi_cs;
  logic              spi_sck;
  logic              spi_mosi;
  logic              spi_miso;
  logic [ADDR_W-1:0] csr_addr;
  logic              csr_wr;
  logic [DATA_W-1:0] csr_wdata;
  logic              csr_rd;
  logic [DATA_W-1:0] csr_rdata;
  logic              frame_abort;

  modport slave (
    input  spi_cs, spi_sck, spi_mosi, csr_rdata,
    output spi_miso, csr_addr, csr_wr, csr_wdata, csr_rd, frame_abort
  );

  modport master (
    output spi_cs, spi_sck, spi_mosi, csr_rdata,
    input  spi_miso, csr_addr, csr_wr, csr_wdata, csr_rd, frame_abort
  );
endinterface

// File: rtl/spi_csr_bridge.sv
// SPI mode-0 slave to 8-bit CSR bus bridge; SCK/CS edges found by oversampling in clk.
// Macro SPI_CSR_AUTOINC_EN: address advances after each data byte; otherwise it stays fixed per frame.
module spi_csr_bridge #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_csr_bridge_if.slave   bus
);
  localparam int unsigned CntW = 3;
`ifdef SPI_CSR_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_e;

  state_e            state_q, state_d;
  logic              sck_q, cs_q;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              ld_q, ld_d;
  logic              abort_q, abort_d;

  logic              sck_rise_c, sck_fall_c, cs_rise_c, cs_fall_c, byte_done_c;
  logic [DATA_W-1:0] rx_byte_c;
  logic [ADDR_W-1:0] addr_inc_c;

  assign sck_rise_c  =  bus.spi_sck & ~sck_q & ~bus.spi_cs;
  assign sck_fall_c  = ~bus.spi_sck &  sck_q & ~bus.spi_cs;
  assign cs_rise_c   =  bus.spi_cs  & ~cs_q;
  assign cs_fall_c   = ~bus.spi_cs  &  cs_q;
  assign rx_byte_c   = {rx_sr_q, bus.spi_mosi};
  assign byte_done_c = sck_rise_c && (bit_cnt_q == CntW'(DATA_W - 1));
  assign addr_inc_c  = addr_q + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sck_q     <= 1'b0;
      cs_q      <= 1'b0;
      bit_cnt_q <= '0;
      rx_sr_q   <= '0;
      tx_sr_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      ld_q      <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sck_q     <= bus.spi_sck;
      cs_q      <= bus.spi_cs;
      bit_cnt_q <= bit_cnt_d;
      rx_sr_q   <= rx_sr_d;
      tx_sr_q   <= tx_sr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      ld_q      <= ld_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_sr_d   = rx_sr_q;
    tx_sr_d   = tx_sr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    ld_d      = rd_q;
    abort_d   = 1'b0;

    // Address moves on only after the write strobe has used it.
    if (wr_q && AutoInc) addr_d = addr_inc_c;
    // Read data arrives the cycle after csr_rd; drop it if the frame already ended.
    if (ld_q && state_q == RDATA) tx_sr_d = bus.csr_rdata;

    if (state_q == IDLE) begin
      if (cs_fall_c) begin
        state_d   = CMD;
        bit_cnt_d = '0;
        rx_sr_d   = '0;
        tx_sr_d   = '0;
      end
    end else if (cs_rise_c) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      tx_sr_d   = '0;
      abort_d   = (bit_cnt_q != '0);
    end else begin
      if (sck_rise_c) begin
        rx_sr_d   = rx_byte_c[DATA_W-2:0];
        bit_cnt_d = bit_cnt_q + CntW'(1);
      end
      // The fall right after a byte boundary keeps the freshly loaded MSB on MISO.
      if (sck_fall_c && bit_cnt_q != '0) tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
      if (byte_done_c) begin
        case (state_q)
          CMD: begin
            addr_d  = rx_byte_c[ADDR_W-1:0];
            rd_d    = rx_byte_c[DATA_W-1];
            state_d = rx_byte_c[DATA_W-1] ? RDATA : WDATA;
          end
          WDATA: begin
            wr_d    = 1'b1;
            wdata_d = rx_byte_c;
          end
          RDATA: begin
            rd_d = 1'b1;
            if (AutoInc) addr_d = addr_inc_c;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.spi_miso    = tx_sr_q[DATA_W-1];
  assign bus.csr_addr    = addr_q;
  assign bus.csr_wr      = wr_q;
  assign bus.csr_wdata   = wdata_q;
  assign bus.csr_rd      = rd_q;
  assign bus.frame_abort = abort_q;
endmodule
